// File: rtl/rv32i_memaccess_ctrl.sv
// rtl/rv32i_memaccess_ctrl.sv - RV32I load/store sequencer onto a pipelined Wishbone data bus.
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN (TIMEOUT_CYCLES then applies).
module rv32i_memaccess_ctrl
`ifdef MEM_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_load,
    input  logic        i_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_flush,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_stall,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_data,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_rd_data,
    output logic        o_rd_valid,
    output logic        o_misaligned,
    output logic        o_bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state;
    logic [1:0]  r_off;
    logic [2:0]  r_funct3;
    logic        r_flushed;

    logic        req_ok;
    logic        misaligned;
    logic        accept;
    logic [3:0]  sel_c;
    logic [31:0] data_c;

    function automatic logic [31:0] load_align(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[8*off +: 8];
        h = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  load_align = {{24{b[7]}}, b};
            3'b100:  load_align = {24'd0, b};
            3'b001:  load_align = {{16{h[15]}}, h};
            3'b101:  load_align = {16'd0, h};
            default: load_align = d;
        endcase
    endfunction

    // funct3[1:0]: 00 byte, 01 half, 1x word
    always_comb begin
        req_ok     = i_start && (i_load || i_store) && !i_flush;
        misaligned = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                     (i_funct3[1] && (i_addr[1:0] != 2'b00));
        accept     = (state == IDLE) && req_ok && !misaligned;
        sel_c      = 4'b1111;
        data_c     = i_wdata;
        if (i_funct3[1:0] == 2'b00) begin
            sel_c  = 4'b0001 << i_addr[1:0];
            data_c = {4{i_wdata[7:0]}};
        end else if (i_funct3[1:0] == 2'b01) begin
            sel_c  = 4'b0011 << i_addr[1:0];
            data_c = {2{i_wdata[15:0]}};
        end
    end

    assign o_stall = (state != IDLE) || accept;

`ifdef MEM_TIMEOUT_EN
    logic [31:0] tmo_cnt;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            o_wb_cyc     <= 1'b0;
            o_wb_stb     <= 1'b0;
            o_wb_we      <= 1'b0;
            o_wb_addr    <= 32'd0;
            o_wb_data    <= 32'd0;
            o_wb_sel     <= 4'd0;
            o_done       <= 1'b0;
            o_rd_valid   <= 1'b0;
            o_rd_data    <= 32'd0;
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
            r_off        <= 2'd0;
            r_funct3     <= 3'd0;
            r_flushed    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt      <= 32'd0;
`endif
        end else begin
            o_done       <= 1'b0;
            o_rd_valid   <= 1'b0;
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_ok && misaligned) begin
                        o_misaligned <= 1'b1;
                    end else if (accept) begin
                        o_wb_cyc  <= 1'b1;
                        o_wb_stb  <= 1'b1;
                        o_wb_we   <= i_store;
                        o_wb_addr <= {i_addr[31:2], 2'b00};
                        o_wb_data <= data_c;
                        o_wb_sel  <= sel_c;
                        r_off     <= i_addr[1:0];
                        r_funct3  <= i_funct3;
                        r_flushed <= 1'b0;
                        state     <= REQ;
`ifdef MEM_TIMEOUT_EN
                        tmo_cnt   <= 32'd0;
`endif
                    end
                end
                REQ: begin
                    if (i_wb_stall) begin
                        // Not yet on the bus, so a flush can simply withdraw the request
                        if (i_flush) begin
                            o_wb_cyc <= 1'b0;
                            o_wb_stb <= 1'b0;
                            state    <= IDLE;
                        end
                    end else begin
                        o_wb_stb <= 1'b0;
                        if (i_wb_ack) begin
                            o_wb_cyc <= 1'b0;
                            state    <= IDLE;
                            if (!(r_flushed || i_flush)) begin
                                o_done     <= 1'b1;
                                o_rd_valid <= !o_wb_we;
                                if (!o_wb_we)
                                    o_rd_data <= load_align(r_funct3, r_off, i_wb_data);
                            end
                        end else begin
                            r_flushed <= r_flushed || i_flush;
                            state     <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (i_wb_ack) begin
                        o_wb_cyc <= 1'b0;
                        state    <= IDLE;
                        if (!(r_flushed || i_flush)) begin
                            o_done     <= 1'b1;
                            o_rd_valid <= !o_wb_we;
                            if (!o_wb_we)
                                o_rd_data <= load_align(r_funct3, r_off, i_wb_data);
                        end
                    end else begin
                        r_flushed <= r_flushed || i_flush;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef MEM_TIMEOUT_EN
            // Watchdog overrides the case above when the bus never answers
            if ((state == REQ || state == WAIT) && !i_wb_ack &&
                !(state == REQ && i_wb_stall && i_flush)) begin
                if (tmo_cnt == TIMEOUT_CYCLES - 1) begin
                    o_wb_cyc  <= 1'b0;
                    o_wb_stb  <= 1'b0;
                    o_bus_err <= 1'b1;
                    state     <= IDLE;
                end else begin
                    tmo_cnt <= tmo_cnt + 32'd1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_rv32i_memaccess_ctrl.sv
// tb/tb_rv32i_memaccess_ctrl.sv - self-checking bench for rv32i_memaccess_ctrl.
module tb_rv32i_memaccess_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 0, i_load = 0, i_store = 0, i_flush = 0;
    logic [2:0]  i_funct3 = 0;
    logic [31:0] i_addr = 0, i_wdata = 0, i_wb_data = 0;
    logic        i_wb_stall = 0, i_wb_ack = 0;
    logic        o_wb_cyc, o_wb_stb, o_wb_we, o_stall, o_done, o_rd_valid, o_misaligned, o_bus_err;
    logic [31:0] o_wb_addr, o_wb_data, o_rd_data;
    logic [3:0]  o_wb_sel;

    always #5 clk = ~clk;

`ifdef MEM_TIMEOUT_EN
    rv32i_memaccess_ctrl #(.TIMEOUT_CYCLES(8)) dut (
`else
    rv32i_memaccess_ctrl dut (
`endif
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_load(i_load), .i_store(i_store),
        .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata), .i_flush(i_flush),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
        .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel), .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack),
        .i_wb_data(i_wb_data), .o_stall(o_stall), .o_done(o_done), .o_rd_data(o_rd_data),
        .o_rd_valid(o_rd_valid), .o_misaligned(o_misaligned), .o_bus_err(o_bus_err)
    );

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        logic        mis;
        logic [3:0]  sel;
        logic [31:0] wbdat;
        logic [31:0] rd;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    vec_t vecs[13];
    vec_t exp_q[$];
    vec_t e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        i_start = 1'b1; i_load = ld; i_store = st; i_funct3 = f3; i_addr = addr; i_wdata = wd;
    endtask

    task automatic idle_inputs();
        i_start = 1'b0; i_load = 1'b0; i_store = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        drive(v.ld, v.st, v.f3, v.addr, v.wdata);
        #1 check("stall_on_accept", {31'd0, o_stall}, {31'd0, !v.mis});
        exp_q.push_back(v);
        @(negedge clk);
        idle_inputs();
        if (v.mis) begin
            e = exp_q.pop_front();
            check("misaligned_pulse", {31'd0, o_misaligned}, 32'd1);
            check("mis_no_cyc", {31'd0, o_wb_cyc}, 32'd0);
            check("mis_no_stall", {31'd0, o_stall}, 32'd0);
            @(negedge clk);
            check("misaligned_one_cycle", {31'd0, o_misaligned}, 32'd0);
            return;
        end
        e = exp_q[0];
        check("req_cyc_stb", {30'd0, o_wb_cyc, o_wb_stb}, 32'd3);
        check("wb_addr", o_wb_addr, {e.addr[31:2], 2'b00});
        check("wb_sel", {28'd0, o_wb_sel}, {28'd0, e.sel});
        check("wb_we", {31'd0, o_wb_we}, {31'd0, e.st});
        if (e.st) check("wb_data", o_wb_data, e.wbdat);
        for (int n = 0; n < v.lat; n++) begin
            @(negedge clk);
            check("busy_stall", {30'd0, o_stall, o_wb_cyc}, 32'd3);
        end
        i_wb_ack = 1'b1; i_wb_data = v.rdata;
        @(negedge clk);
        i_wb_ack = 1'b0;
        e = exp_q.pop_front();
        check("done", {31'd0, o_done}, 32'd1);
        check("rd_valid", {31'd0, o_rd_valid}, {31'd0, e.ld});
        if (e.ld) check("rd_data", o_rd_data, e.rd);
        check("released", {30'd0, o_stall, o_wb_cyc}, 32'd0);
    endtask

    initial begin
        //            ld    st    f3      addr          wdata         rdata         lat mis   sel      wbdat         rd
        vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 2, 1'b0, 4'b1111, 32'h0,        32'hDEAD_BEEF};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h8011_2233, 1, 1'b0, 4'b1000, 32'h0,        32'hFFFF_FF80};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h8011_2233, 0, 1'b0, 4'b1000, 32'h0,        32'h0000_0080};
        vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h8011_2233, 1, 1'b0, 4'b1100, 32'h0,        32'h0000_8011};
        vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h8011_2233, 3, 1'b0, 4'b1100, 32'h0,        32'hFFFF_8011};
        vecs[5]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0,        32'h8011_2233, 0, 1'b0, 4'b0010, 32'h0,        32'h0000_0022};
        vecs[6]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0,        2, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h0000_00A5, 32'h0,        1, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 32'h0,        0, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[10] = '{1'b1, 1'b0, 3'b001, 32'h0000_0103, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[11] = '{1'b0, 1'b1, 3'b010, 32'h0000_0302, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[12] = '{1'b1, 1'b0, 3'b001, 32'h0000_0100, 32'h0,        32'h0000_7FFF, 1, 1'b0, 4'b0011, 32'h0,        32'h0000_7FFF};

        repeat (2) @(negedge clk);
        check("rst_ctrl", {24'd0, o_wb_cyc, o_wb_stb, o_wb_we, o_done, o_rd_valid, o_misaligned,
                           o_bus_err, o_stall}, 32'd0);
        check("rst_regs", o_wb_addr | o_wb_data | o_rd_data | {28'd0, o_wb_sel}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Flush in IDLE suppresses acceptance
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0);
        i_flush = 1'b1;
        #1 check("idle_flush_stall", {31'd0, o_stall}, 32'd0);
        @(negedge clk);
        idle_inputs(); i_flush = 1'b0;
        check("idle_flush_cyc", {31'd0, o_wb_cyc}, 32'd0);

        // Flush while the slave is stalling: request withdrawn, no completion
        i_wb_stall = 1'b1;
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0);
        @(negedge clk);
        idle_inputs();
        check("stall_req_held", {30'd0, o_wb_cyc, o_wb_stb}, 32'd3);
        @(negedge clk);
        check("stall_req_held2", {30'd0, o_wb_cyc, o_wb_stb}, 32'd3);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        check("req_flush_drop", {29'd0, o_wb_cyc, o_wb_stb, o_done}, 32'd0);
        check("req_flush_stall", {31'd0, o_stall}, 32'd0);
        @(negedge clk);
        i_wb_stall = 1'b0;
        check("req_flush_no_done", {31'd0, o_done}, 32'd0);

        // Flush in WAIT: ack consumed, result discarded; start while busy ignored
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        i_flush = 1'b1;
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'h0);
        @(negedge clk);
        idle_inputs(); i_flush = 1'b0;
        check("busy_start_ignored", o_wb_addr, 32'h0000_0500);
        i_wb_ack = 1'b1; i_wb_data = 32'h1111_2222;
        @(negedge clk);
        i_wb_ack = 1'b0;
        check("wait_flush_done", {30'd0, o_done, o_rd_valid}, 32'd0);
        check("wait_flush_idle", {30'd0, o_wb_cyc, o_stall}, 32'd0);
        check("wait_flush_rd_kept", o_rd_data, 32'h0000_7FFF);

        // Unanswered access
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0700, 32'h0);
        @(negedge clk);
        idle_inputs();
`ifdef MEM_TIMEOUT_EN
        begin
            int n;
            n = 1;
            while (!o_bus_err && n < 30) begin
                @(negedge clk);
                n++;
            end
            check("timeout_cycle", n, 9);
            check("timeout_state", {29'd0, o_wb_cyc, o_stall, o_done}, 32'd0);
            @(negedge clk);
            check("bus_err_one_cycle", {31'd0, o_bus_err}, 32'd0);
        end
`else
        repeat (20) @(negedge clk);
        check("no_timeout_cyc", {30'd0, o_wb_cyc, o_bus_err}, 32'd2);
        i_wb_ack = 1'b1; i_wb_data = 32'h0BAD_F00D;
        @(negedge clk);
        i_wb_ack = 1'b0;
        check("late_ack_done", o_rd_data, 32'h0BAD_F00D);
`endif

        // Asynchronous reset mid-transaction drops the bus at once
        @(negedge clk);
        drive(1'b0, 1'b1, 3'b010, 32'h0000_0800, 32'h5555_AAAA);
        @(negedge clk);
        idle_inputs();
        check("pre_reset_cyc", {31'd0, o_wb_cyc}, 32'd1);
        rst_n = 1'b0;
        #1 check("async_reset_drop", {29'd0, o_wb_cyc, o_wb_stb, o_stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32i_memaccess_ctrl.md
Name: rv32i_memaccess_ctrl

Overview:
Sequences data-memory load/store transactions issued from the execute stage into the memory-access stage over a pipelined Wishbone-style bus. It holds the pipeline stall for the whole transaction and generates byte selects and store-data lanes. It aligns and sign-extends load data and flags misaligned accesses. It sits between the execute-stage registers (opcode, funct3, ALU address result, rs2) and the data-memory bus.

Parameters:
TIMEOUT_CYCLES, 255, bus cycles in REQ+WAIT before abort; used only when MEM_TIMEOUT_EN is defined.

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  execute-stage ce and load/store valid this cycle
i_load  input  1  instruction is LOAD
i_store  input  1  instruction is STORE
i_funct3  input  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
i_addr  input  32  effective byte address (ALU result)
i_wdata  input  32  store data (rs2)
i_flush  input  1  discard current/next access
o_wb_cyc  output  1  bus cycle active
o_wb_stb  output  1  request strobe
o_wb_we  output  1  write enable
o_wb_addr  output  32  word address {i_addr[31:2],2'b00}
o_wb_data  output  32  lane-replicated store data
o_wb_sel  output  4  byte selects
i_wb_stall  input  1  slave not accepting stb
i_wb_ack  input  1  transaction complete
i_wb_data  input  32  read data
o_stall  output  1  hold pipeline
o_done  output  1  one-cycle completion pulse
o_rd_data  output  32  aligned, extended load result
o_rd_valid  output  1  o_rd_data valid (loads only, with o_done)
o_misaligned  output  1  one-cycle misaligned-access pulse
o_bus_err  output  1  one-cycle timeout pulse

Behaviour:
- Reset: state IDLE; o_wb_cyc, o_wb_stb, o_wb_we, o_done, o_rd_valid, o_misaligned, o_bus_err = 0; o_wb_sel = 0; o_wb_addr, o_wb_data, o_rd_data = 0. Reset mid-transaction drops cyc/stb immediately.
- States: IDLE, REQ, WAIT.
- IDLE: accept when i_start && (i_load||i_store) && !i_flush.
- Misalignment: H/HU with addr[0]=1, or W with addr[1:0]!=0 -> no bus cycle; o_misaligned=1 next cycle; stay IDLE.
- Aligned access -> register addr/sel/data/we; go REQ with cyc=stb=1 next cycle.
- REQ: hold stb while i_wb_stall. On !i_wb_stall: stb=0 next cycle.
  - ack same cycle -> IDLE, else -> WAIT.
- WAIT: cyc=1, stb=0 until i_wb_ack -> IDLE.
- Completion: o_done=1 for one cycle after ack. Loads also set o_rd_valid=1 and o_rd_data.
- o_stall (combinational): 1 when state!=IDLE, or in IDLE when an aligned access is being accepted. 0 on the completion cycle and after.
- Store lanes:
  - SB: sel=4'b0001<<addr[1:0], data={4{wdata[7:0]}}.
  - SH: sel=4'b0011<<addr[1:0], data={2{wdata[15:0]}}.
  - SW: sel=4'b1111, data=wdata.
- Load lanes: loads use sel as for stores.
  - B/BU select byte addr[1:0] from i_wb_data; H/HU select half addr[1].
  - B/H sign-extend; BU/HU zero-extend.
- Flush:
  - In IDLE: suppresses acceptance.
  - In REQ before stb accepted (i_wb_stall=1): drop cyc/stb next cycle, return IDLE, no o_done.
  - Once accepted: wait for ack, then return IDLE with o_done=o_rd_valid=0 (result discarded). A flushed store already accepted still completes on the bus.
- i_start while busy is ignored. The caller is held by o_stall.

Optional Feature:
MEM_TIMEOUT_EN: defines a counter cleared on entry to REQ, incremented each REQ/WAIT cycle without ack. On reaching TIMEOUT_CYCLES: cyc/stb drop, o_bus_err=1 for one cycle, state IDLE, o_stall released, no o_done. Without the macro: o_bus_err tied 0, WAIT holds indefinitely, no counter logic.

Test Plan:
- LW addr 0x100, no stall, ack 2 cycles after stb, i_wb_data 0xDEADBEEF -> wb_addr 0x100, sel 1111, o_rd_data 0xDEADBEEF with o_done/o_rd_valid; o_stall high from accept through WAIT.
- LB addr 0x103, i_wb_data 0x80112233 -> sel 1000, o_rd_data 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x00008011.
- SH addr 0x202, wdata 0x1234ABCD -> we=1, sel 1100, wb_data 0xABCDABCD, o_done with o_rd_valid=0.
- LW addr 0x101 -> no cyc; o_misaligned pulse one cycle; o_stall never asserted beyond accept cycle.
- i_wb_stall held 3 cycles, i_flush in 2nd -> cyc/stb drop, no o_done; repeat with flush in WAIT -> ack consumed, o_done=0.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, never ack -> o_bus_err pulse after 8 cycles, cyc=0, state IDLE; without macro cyc stays high.
